// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared states, command constants and helpers for the SPI flash word reader
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_OUT,
        SHIFT_IN,
        RESP,
        GUARD
    } state_t;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam int         SPI_ADDR_W    = 24;
    localparam int         SPI_WORD_BITS = 32;

    // The flash streams bytes in address order; the first one belongs in the low byte.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_sck_gen.sv
// rtl/spi_flash_sck_gen.sv - SCK divider with end-of-low-phase and end-of-high-phase strobes
module spi_flash_sck_gen
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic shift_stb,
    output logic sample_stb
);

    logic [7:0] div_cnt;
    logic       phase_end;

    assign phase_end  = en && (div_cnt == 8'(CLK_DIV - 1));
    assign shift_stb  = phase_end && !sck;
    assign sample_stb = phase_end && sck;

    // Disabled means parked low with the divider cleared, so every transaction starts on a full low phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= 8'd0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= 8'd0;
            sck     <= 1'b0;
        end else if (phase_end) begin
            div_cnt <= 8'd0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_flash_word_reader.sv
// rtl/spi_flash_word_reader.sv - fetches one little-endian 32-bit word per request with the SPI 0x03 READ command
module spi_flash_word_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SPI_ADDR_W-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic                  flash_csb,
    output logic                  flash_clk,
    output logic                  flash_io0,
    input  logic                  flash_io1
);

    state_t      state;
    logic [31:0] out_sr;
    logic [31:0] in_sr;
    logic [5:0]  bit_cnt;
    logic [7:0]  idle_cnt;
    logic        sck_en;
    logic        shift_stb;
    logic        sample_stb;
    logic        guard_done;

    assign req_ready  = (state == IDLE);
    assign sck_en     = ((state == SHIFT_OUT) || (state == SHIFT_IN)) && !flash_csb;
    // idle_cnt holds the number of edges since flash_csb rose; the IDLE hop costs one more edge.
    assign guard_done = (idle_cnt >= 8'(CS_IDLE - 1));

    spi_flash_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .en         (sck_en),
        .sck        (flash_clk),
        .shift_stb  (shift_stb),
        .sample_stb (sample_stb)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            out_sr    <= 32'd0;
            in_sr     <= 32'd0;
            bit_cnt   <= 6'd0;
            idle_cnt  <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            busy      <= 1'b0;
            flash_csb <= 1'b1;
            flash_io0 <= 1'b0;
        end else begin
            if (shift_stb) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (((state == RESP) || (state == GUARD)) && (idle_cnt != 8'hFF)) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        out_sr  <= {SPI_CMD_READ, req_addr};
                        bit_cnt <= 6'd0;
                        busy    <= 1'b1;
                        state   <= SHIFT_OUT;
                    end
                end
                SHIFT_OUT: begin
                    if (flash_csb) begin
                        flash_csb <= 1'b0;
                        flash_io0 <= out_sr[31];
                    end else if (sample_stb) begin
                        // MOSI moves on the falling edge so it is settled through the next low phase.
                        if (bit_cnt == 6'(SPI_WORD_BITS)) begin
                            flash_io0 <= 1'b0;
                            state     <= SHIFT_IN;
                        end else begin
                            flash_io0 <= out_sr[30];
                            out_sr    <= {out_sr[30:0], 1'b0};
                        end
                    end
                end
                SHIFT_IN: begin
                    if (sample_stb) begin
                        in_sr <= {in_sr[30:0], flash_io1};
                        // The 64th rising edge wraps bit_cnt back to zero.
                        if (bit_cnt == 6'd0) begin
                            rsp_data  <= byte_swap32({in_sr[30:0], flash_io1});
                            rsp_valid <= 1'b1;
                            flash_csb <= 1'b1;
                            idle_cnt  <= 8'd1;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (guard_done) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (guard_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
